serial_subtractor: RTL and testbench

Bit-serial two's-complement subtractor. It computes Diff = A − B − Bin one bit per clock, LSB first, using a single full-subtractor cell and a borrow flip-flop. It is the sequential, inverse-operation companion of the team's parallel ripple-carry adder. It sits in the arithmetic library for area-constrained datapaths where WIDTH cycles of latency are acceptable.

---
 rtl/serial_subtractor.sv | 134 +++++++++++++
 tb/tb_serial_subtractor.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a - b - bin, LSB first,
// one full-subtractor cell plus a borrow flop, results published on completion.
//
// state | meaning
// IDLE  | waiting for start, results held
// SHIFT | one operand bit processed per cycle, busy=1
// DONE  | one-cycle done pulse, start accepted back-to-back
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic [WIDTH-1:0] rd;
    logic [WIDTH-1:0] rd_nxt;
    logic [CW-1:0]    cnt;
    logic             borrow;
    logic             borrow_nxt;
    logic             d_bit;
    logic             a_sign;
    logic             b_sign;
    logic             load;
    logic             last_bit;

    always_comb begin
        d_bit      = ra[0] ^ rb[0] ^ borrow;
        borrow_nxt = (~ra[0] & rb[0]) | (~(ra[0] ^ rb[0]) & borrow);
        rd_nxt     = {d_bit, rd[WIDTH-1:1]};
        last_bit   = (cnt == LAST);
    end

    // start is only honoured when no operation is in flight
    always_comb begin
        load      = 1'b0;
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (last_bit) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = SHIFT;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt == SHIFT);
            done  <= (state_nxt == DONE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ra     <= '0;
            rb     <= '0;
            rd     <= '0;
            cnt    <= '0;
            borrow <= 1'b0;
            a_sign <= 1'b0;
            b_sign <= 1'b0;
        end else if (load) begin
            ra     <= a;
            rb     <= b;
            rd     <= '0;
            cnt    <= '0;
            borrow <= bin;
            a_sign <= a[WIDTH-1];
            b_sign <= b[WIDTH-1];
        end else if (state == SHIFT) begin
            ra     <= {1'b0, ra[WIDTH-1:1]};
            rb     <= {1'b0, rb[WIDTH-1:1]};
            rd     <= rd_nxt;
            cnt    <= cnt + CW'(1);
            borrow <= borrow_nxt;
        end
    end

    // results change only on the edge that enters DONE, so diff never shows partial bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            diff <= '0;
            bout <= 1'b0;
            ovf  <= 1'b0;
        end else if (state == SHIFT && last_bit) begin
            diff <= rd_nxt;
            bout <= borrow_nxt;
            ovf  <= (a_sign != b_sign) && (d_bit != a_sign);
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and random checks of serial_subtractor (WIDTH=8): latency, results,
// handshake rules and asynchronous reset.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;

    int n_assert = 0;
    int n_fail   = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .a    (a),
        .b    (b),
        .bin  (bin),
        .busy (busy),
        .done (done),
        .diff (diff),
        .bout (bout),
        .ovf  (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // present operands on a negedge; accepted at the next posedge; returns on the negedge after it
    task automatic start_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi);
        start = 1'b1;
        a     = av;
        b     = bv;
        bin   = bi;
        @(negedge clk);
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        bin   = 1'($urandom);
    endtask

    // counts negedges until done, bounded; checks diff stays at hold_val meanwhile
    task automatic wait_done(input int n0, input logic [W-1:0] hold_val, input string tag,
                             output int n);
        n = n0;
        while (!done && n < 20) begin
            if (diff !== hold_val) check({tag, "_hold"}, 32'(diff), 32'(hold_val));
            @(negedge clk);
            n++;
        end
    endtask

    task automatic check_result(input string tag, input logic [W-1:0] ed, input logic eb,
                                input logic eo);
        check({tag, "_diff"}, 32'(diff), 32'(ed));
        check({tag, "_bout"}, 32'(bout), 32'(eb));
        check({tag, "_ovf"},  32'(ovf),  32'(eo));
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic bi, input logic [W-1:0] ed, input logic eb, input logic eo);
        int n;
        logic [W-1:0] old;
        old = diff;
        start_op(av, bv, bi);
        check({tag, "_busy"}, 32'(busy), 32'd1);
        wait_done(0, old, tag, n);
        check({tag, "_lat"}, 32'(n), 32'd8);
        check_result(tag, ed, eb, eo);
        check({tag, "_busy_done"}, 32'(busy), 32'd0);
        @(negedge clk);
        check({tag, "_done_1cyc"}, 32'(done), 32'd0);
    endtask

    initial begin
        int n;
        logic [W:0]   full;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rbi;
        logic [W-1:0] prev;

        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        bin   = 1'b0;

        // reset held with random activity on the inputs
        repeat (4) begin
            @(negedge clk);
            start = 1'($urandom);
            a     = $urandom;
            b     = $urandom;
            bin   = 1'($urandom);
        end
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_diff", 32'(diff), 32'd0);
        check("rst_bout", 32'(bout), 32'd0);
        check("rst_ovf",  32'(ovf),  32'd0);
        start = 1'b0;
        rst_n = 1'b1;

        repeat (5) @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_done", 32'(done), 32'd0);
        check("idle_diff", 32'(diff), 32'd0);

        run_op("v50m20", 8'h50, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0);
        run_op("v20m50", 8'h20, 8'h50, 1'b0, 8'hD0, 1'b1, 1'b0);
        run_op("v80m01", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
        run_op("v7fmff", 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1);
        run_op("v00bin", 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0);
        run_op("vaabin", 8'hAA, 8'hAA, 1'b1, 8'hFF, 1'b1, 1'b0);

        // start pulsed mid-shift is ignored
        prev = diff;
        start_op(8'h50, 8'h20, 1'b0);
        n = 0;
        repeat (3) begin
            @(negedge clk);
            n++;
        end
        start_op(8'h01, 8'h02, 1'b1);
        n++;
        wait_done(n, prev, "ign", n);
        check("ign_lat", 32'(n), 32'd8);
        check_result("ign", 8'h30, 1'b0, 1'b0);
        @(negedge clk);
        check("ign_idle_busy", 32'(busy), 32'd0);
        check("ign_idle_done", 32'(done), 32'd0);

        // back-to-back: start during the done cycle
        start_op(8'h10, 8'h03, 1'b0);
        wait_done(0, 8'h30, "b2b1", n);
        check("b2b1_lat", 32'(n), 32'd8);
        check_result("b2b1", 8'h0D, 1'b0, 1'b0);
        start_op(8'h03, 8'h10, 1'b1);
        check("b2b2_busy", 32'(busy), 32'd1);
        check("b2b2_done_low", 32'(done), 32'd0);
        wait_done(0, 8'h0D, "b2b2", n);
        check("b2b2_lat", 32'(n), 32'd8);
        check_result("b2b2", 8'hF2, 1'b1, 1'b0);
        @(negedge clk);

        // reset mid-operation aborts with immediate zeros
        start_op(8'h50, 8'h20, 1'b0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mrst_busy", 32'(busy), 32'd0);
        check("mrst_diff", 32'(diff), 32'd0);
        check("mrst_bout", 32'(bout), 32'd0);
        check("mrst_ovf",  32'(ovf),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) n++;
        end
        check("mrst_no_done", 32'(n), 32'd0);
        check("mrst_diff_held", 32'(diff), 32'd0);
        run_op("post_rst", 8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0);

        // random regression against A - B - Bin
        for (int i = 0; i < 1000; i++) begin
            ra   = $urandom;
            rb   = $urandom;
            rbi  = 1'($urandom);
            full = {1'b0, ra} - {1'b0, rb} - {{W{1'b0}}, rbi};
            prev = diff;
            start_op(ra, rb, rbi);
            wait_done(0, prev, "rnd", n);
            check("rnd_lat", 32'(n), 32'd8);
            check_result("rnd", full[W-1:0], full[W],
                         (ra[W-1] != rb[W-1]) && (full[W-1] != ra[W-1]));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
